// File: rtl/mem_capture.sv
// mem_capture: arms on a pulse, waits for a frame boundary, then writes one
// complete AXI4-Stream frame into a single-port memory from address 0 and
// reports its length and whether it overflowed the memory.
module mem_capture #(
   parameter int C_MEM_SIZE   = 4096,
   parameter int C_DATA_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               arm,
   output logic                               busy,
   output logic                               frame_done,
   output logic [$clog2(C_MEM_SIZE+1)-1:0]    frame_length,
   output logic                               overflow,
   output logic                               mem_clk,
   output logic                               mem_rst,
   output logic                               mem_en,
   output logic                               mem_we,
   output logic [$clog2(C_MEM_SIZE)-1:0]      mem_addr,
   output logic [C_DATA_WIDTH-1:0]            mem_wdata,
   input  logic [C_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic                               s_axis_tlast,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready
);

   localparam int AW = $clog2(C_MEM_SIZE);
   localparam int CW = $clog2(C_MEM_SIZE+1);
   localparam logic [CW-1:0] MEM_SIZE_C = CW'(C_MEM_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAPTURE} state_t;

   state_t                  state_q, state_d;
   logic                    in_frame_q, in_frame_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [CW-1:0]           len_q, len_d;
   logic                    ovf_q, ovf_d;
   logic                    wr_q, wr_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                    beat;

   // The source is never stalled except while reset is held.
   assign s_axis_tready = ~rst;
   assign beat          = s_axis_tvalid & s_axis_tready;

   assign mem_clk      = clk;
   assign mem_rst      = rst;
   assign mem_en       = wr_q;
   assign mem_we       = wr_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign frame_length = len_q;
   assign overflow     = ovf_q;

   // Frame-boundary tracker, updated by every accepted beat in any state.
   always_comb begin
      in_frame_d = in_frame_q;
      if (beat) in_frame_d = ~s_axis_tlast;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_frame_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_frame_q <= in_frame_d;
      end
   end

   // Next state: an arm coinciding with a beat uses the post-beat frame
   // position, so an arm on a tlast beat starts capturing immediately.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (arm) state_d = in_frame_d ? S_SYNC : S_CAPTURE;
         S_SYNC:    if (beat && s_axis_tlast) state_d = S_CAPTURE;
         S_CAPTURE: if (beat && s_axis_tlast) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs and datapath next values: memory write, counters, status.
   always_comb begin
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      len_d   = len_q;
      ovf_d   = ovf_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (arm) begin
               cnt_d  = '0;
               len_d  = '0;
               ovf_d  = 1'b0;
               busy_d = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (beat) begin
               if (cnt_q < MEM_SIZE_C) begin
                  wr_d    = 1'b1;
                  addr_d  = cnt_q[AW-1:0];
                  wdata_d = s_axis_tdata;
                  cnt_d   = cnt_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (s_axis_tlast) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  len_d  = (cnt_q == MEM_SIZE_C) ? MEM_SIZE_C : cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_capture.sv
// Testbench for mem_capture with an 8-word memory: table-driven frames plus
// hand-written sequences, memory writes and frame completions scored against
// queues of expected results.
module tb_mem_capture;

   localparam int MS = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       arm;
   logic       busy, frame_done, overflow;
   logic [3:0] frame_length;
   logic       mem_clk, mem_rst, mem_en, mem_we;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tlast, s_axis_tvalid, s_axis_tready;

   int tests = 0;
   int fails = 0;

   typedef struct { logic [2:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [3:0] len; logic ovf; logic wr; } dn_t;
   typedef struct { int nbeats; logic [7:0] d0; int gap; int exp_len; logic exp_ovf; } vec_t;

   wr_t  wq[$];
   dn_t  dq[$];
   vec_t vecs[5];

   mem_capture #(.C_MEM_SIZE(MS), .C_DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .arm(arm), .busy(busy), .frame_done(frame_done),
      .frame_length(frame_length), .overflow(overflow), .mem_clk(mem_clk),
      .mem_rst(mem_rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write and every frame_done must match the next expectation.
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (!rst) begin
         if (mem_en) begin
            if (wq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", mem_addr, w.addr);
               chk("wr_data", mem_wdata, w.data);
               chk("wr_we", mem_we, 1);
            end
         end
         if (frame_done) begin
            if (dq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: got frame_done=1 length %0d, expected no done", frame_length);
            end else begin
               d = dq.pop_front();
               chk("done_len", frame_length, d.len);
               chk("done_ovf", overflow, d.ovf);
               chk("done_busy", busy, 0);
               chk("done_wr_align", mem_en, d.wr);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic last, input int gap, input logic with_arm);
      idle(gap);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last; arm = with_arm;
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; arm = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      wr_t w;
      w.addr = a[2:0]; w.data = d;
      wq.push_back(w);
   endtask

   task automatic push_dn(input int len, input logic ovf, input logic wr);
      dn_t d;
      d.len = len[3:0]; d.ovf = ovf; d.wr = wr;
      dq.push_back(d);
   endtask

   task automatic run_frame(input int n, input logic [7:0] d0, input int gap,
                            input logic capture, input int exp_len, input logic exp_ovf);
      for (int i = 0; i < n; i++) begin
         if (capture) begin
            if (i < MS) push_wr(i, d0 + 8'(i));
            if (i == n-1) push_dn(exp_len, exp_ovf, i < MS);
         end
         send_beat(d0 + 8'(i), i == n-1, gap, 1'b0);
      end
   endtask

   task automatic wait_done(input int bound);
      int i;
      for (i = 0; i < bound && (dq.size() != 0 || wq.size() != 0); i++) @(posedge clk);
      #1;
      if (dq.size() != 0 || wq.size() != 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got %0d writes and %0d dones pending, expected 0", wq.size(), dq.size());
         wq.delete(); dq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{nbeats: 5,  d0: 8'h11, gap: 0, exp_len: 5, exp_ovf: 1'b0};
      vecs[1] = '{nbeats: 1,  d0: 8'h7E, gap: 3, exp_len: 1, exp_ovf: 1'b0};
      vecs[2] = '{nbeats: 8,  d0: 8'h40, gap: 1, exp_len: 8, exp_ovf: 1'b0};
      vecs[3] = '{nbeats: 10, d0: 8'h00, gap: 0, exp_len: 8, exp_ovf: 1'b1};
      vecs[4] = '{nbeats: 3,  d0: 8'hC0, gap: 2, exp_len: 3, exp_ovf: 1'b0};

      rst = 1'b1; arm = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
      idle(3);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_len", frame_length, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_rst", mem_rst, 1);
      rst = 1'b0;
      idle(1);
      chk("tready_run", s_axis_tready, 1);

      // Table-driven frames, each armed from idle.
      for (int v = 0; v < 5; v++) begin
         pulse_arm();
         chk("busy_after_arm", busy, 1);
         chk("len_cleared", frame_length, 0);
         chk("ovf_cleared", overflow, 0);
         run_frame(vecs[v].nbeats, vecs[v].d0, vecs[v].gap, 1'b1, vecs[v].exp_len, vecs[v].exp_ovf);
         wait_done(40);
         chk("busy_low_after", busy, 0);
         idle(2);
         chk("len_hold", frame_length, vecs[v].exp_len);
         chk("ovf_hold", overflow, vecs[v].exp_ovf);
      end

      // Arm together with beat 2 of a 4-beat frame: that frame is skipped.
      send_beat(8'h50, 1'b0, 0, 1'b0);
      send_beat(8'h51, 1'b0, 0, 1'b1);
      chk("busy_sync", busy, 1);
      send_beat(8'h52, 1'b0, 0, 1'b0);
      send_beat(8'h53, 1'b1, 0, 1'b0);
      run_frame(3, 8'hA0, 0, 1'b1, 3, 1'b0);
      wait_done(40);
      chk("len_after_sync", frame_length, 3);

      // Arm together with the tlast beat of an unarmed frame: next frame captured directly.
      send_beat(8'h60, 1'b0, 0, 1'b0);
      send_beat(8'h61, 1'b1, 0, 1'b1);
      run_frame(2, 8'h70, 0, 1'b1, 2, 1'b0);
      wait_done(40);

      // Reset after beat 2 of a capture, midway through a frame.
      pulse_arm();
      push_wr(0, 8'h90); send_beat(8'h90, 1'b0, 0, 1'b0);
      push_wr(1, 8'h91); send_beat(8'h91, 1'b0, 0, 1'b0);
      idle(1);
      rst = 1'b1;
      idle(1);
      chk("abort_busy", busy, 0);
      chk("abort_mem_addr", mem_addr, 0);
      chk("abort_mem_wdata", mem_wdata, 0);
      chk("abort_tready", s_axis_tready, 0);
      rst = 1'b0;
      idle(1);
      pulse_arm();
      run_frame(2, 8'hB0, 0, 1'b1, 2, 1'b0);
      wait_done(40);
      chk("len_after_abort", frame_length, 2);

      // Extra arm during capture, then frames with no arm at all.
      pulse_arm();
      push_wr(0, 8'hD0); send_beat(8'hD0, 1'b0, 0, 1'b0);
      pulse_arm();
      push_wr(1, 8'hD1); send_beat(8'hD1, 1'b0, 1, 1'b0);
      push_wr(2, 8'hD2); push_dn(3, 1'b0, 1'b1); send_beat(8'hD2, 1'b1, 0, 1'b0);
      wait_done(40);
      run_frame(3, 8'hE0, 0, 1'b0, 0, 1'b0);
      run_frame(2, 8'hF0, 1, 1'b0, 0, 1'b0);
      idle(3);
      chk("unarmed_busy", busy, 0);
      chk("unarmed_len_hold", frame_length, 3);

      chk("wq_empty", wq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
